// File: rtl/cache_defs.sv
// Shared data-cache definitions: default index width and the write-back
// controller state encoding.
package cache_defs;

  localparam int unsigned DCACHE_IDX_BITS = 6;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    WRBACK,
    ALLOC,
    REFILL_RD,
    FLUSH_RD,
    FLUSH_CHECK,
    FLUSH_WRB,
    FLUSH_CLEAN,
    FLUSH_NEXT,
    FLUSH_DONE
  } type_wb_dcache_states_e;

endpackage

// File: rtl/wb_dcache_controller.sv
// Write-back data-cache controller: sequences hit/miss handling with victim
// writeback and refill, and a full-cache flush walk driven by an evict counter.
module wb_dcache_controller #(
  parameter int unsigned DCACHE_IDX_BITS = cache_defs::DCACHE_IDX_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsummu2dcache_req_i,
  input  logic                       lsummu2dcache_wr_i,
  output logic                       dcache2lsummu_ack_o,
  input  logic                       dcache_flush_i,
  output logic                       dcache_flush_ack_o,
  input  logic                       cache_hit_i,
  input  logic                       cache_evict_req_i,
  output logic                       cache_req_o,
  output logic                       cache_wr_o,
  output logic                       cache_line_wr_o,
  output logic                       cache_line_clean_o,
  output logic                       cache_wrb_req_o,
  output logic                       dcache_flush_o,
  output logic [DCACHE_IDX_BITS-1:0] evict_index_o,
  output logic                       dcache2mem_req_o,
  output logic                       dcache2mem_wr_o,
  input  logic                       mem2dcache_ack_i
);

  import cache_defs::*;

  localparam logic [DCACHE_IDX_BITS-1:0] LAST_IDX = '1;

  type_wb_dcache_states_e      state_q, state_d;
  logic [DCACHE_IDX_BITS-1:0]  evict_cnt_q, evict_cnt_d;
  logic                        wr_q, wr_d;

  // State, flush line counter and captured access direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      evict_cnt_q <= '0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      evict_cnt_q <= evict_cnt_d;
      wr_q        <= wr_d;
    end
  end

  // Next state and output decode; everything is held low while rst is high.
  always_comb begin
    state_d             = state_q;
    evict_cnt_d         = evict_cnt_q;
    wr_d                = wr_q;
    dcache2lsummu_ack_o = 1'b0;
    dcache_flush_ack_o  = 1'b0;
    cache_req_o         = 1'b0;
    cache_wr_o          = 1'b0;
    cache_line_wr_o     = 1'b0;
    cache_line_clean_o  = 1'b0;
    cache_wrb_req_o     = 1'b0;
    dcache_flush_o      = 1'b0;
    evict_index_o       = '0;
    dcache2mem_req_o    = 1'b0;
    dcache2mem_wr_o     = 1'b0;

    if (!rst) begin
      evict_index_o = evict_cnt_q;
      unique case (state_q)
        IDLE: begin
          if (dcache_flush_i) begin
            evict_cnt_d = '0;
            state_d     = FLUSH_RD;
          end else if (lsummu2dcache_req_i) begin
            cache_req_o = 1'b1;
            wr_d        = lsummu2dcache_wr_i;
            state_d     = CHECK;
          end
        end
        CHECK: begin
          // The store direction is latched so a dropped request still completes.
          if (cache_hit_i) begin
            dcache2lsummu_ack_o = 1'b1;
            cache_wr_o          = wr_q;
            state_d             = IDLE;
          end else if (cache_evict_req_i) begin
            state_d = WRBACK;
          end else begin
            state_d = ALLOC;
          end
        end
        WRBACK: begin
          cache_wrb_req_o  = 1'b1;
          dcache2mem_req_o = 1'b1;
          dcache2mem_wr_o  = 1'b1;
          if (mem2dcache_ack_i) state_d = ALLOC;
        end
        ALLOC: begin
          dcache2mem_req_o = 1'b1;
          if (mem2dcache_ack_i) begin
            cache_line_wr_o = 1'b1;
            state_d         = REFILL_RD;
          end
        end
        REFILL_RD: begin
          cache_req_o = 1'b1;
          state_d     = CHECK;
        end
        FLUSH_RD: begin
          dcache_flush_o = 1'b1;
          cache_req_o    = 1'b1;
          state_d        = FLUSH_CHECK;
        end
        FLUSH_CHECK: begin
          dcache_flush_o = 1'b1;
          state_d        = cache_evict_req_i ? FLUSH_WRB : FLUSH_NEXT;
        end
        FLUSH_WRB: begin
          dcache_flush_o   = 1'b1;
          cache_wrb_req_o  = 1'b1;
          dcache2mem_req_o = 1'b1;
          dcache2mem_wr_o  = 1'b1;
          if (mem2dcache_ack_i) state_d = FLUSH_CLEAN;
        end
        FLUSH_CLEAN: begin
          dcache_flush_o     = 1'b1;
          cache_line_clean_o = 1'b1;
          state_d            = FLUSH_NEXT;
        end
        FLUSH_NEXT: begin
          if (evict_cnt_q == LAST_IDX) begin
            state_d = FLUSH_DONE;
          end else begin
            evict_cnt_d = evict_cnt_q + DCACHE_IDX_BITS'(1);
            state_d     = FLUSH_RD;
          end
        end
        FLUSH_DONE: begin
          dcache_flush_ack_o = 1'b1;
          state_d            = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dcache_controller.sv
// Self-checking bench for wb_dcache_controller with a RAM/memory responder
// model and a scoreboard of expected memory transfers and access acks.
module tb_wb_dcache_controller;

  localparam int unsigned IDX = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req = 1'b0;
  logic           wr_i = 1'b0;
  logic           ack_o;
  logic           dcache_flush_i = 1'b0;
  logic           dcache_flush_ack_o;
  logic           cache_hit_i = 1'b0;
  logic           cache_evict_req_i = 1'b0;
  logic           cache_req_o, cache_wr_o, cache_line_wr_o, cache_line_clean_o;
  logic           cache_wrb_req_o, dcache_flush_o;
  logic [IDX-1:0] evict_index_o;
  logic           dcache2mem_req_o, dcache2mem_wr_o;
  logic           mem2dcache_ack_i = 1'b0;

  wb_dcache_controller #(.DCACHE_IDX_BITS(IDX)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsummu2dcache_req_i (req),
    .lsummu2dcache_wr_i  (wr_i),
    .dcache2lsummu_ack_o (ack_o),
    .dcache_flush_i      (dcache_flush_i),
    .dcache_flush_ack_o  (dcache_flush_ack_o),
    .cache_hit_i         (cache_hit_i),
    .cache_evict_req_i   (cache_evict_req_i),
    .cache_req_o         (cache_req_o),
    .cache_wr_o          (cache_wr_o),
    .cache_line_wr_o     (cache_line_wr_o),
    .cache_line_clean_o  (cache_line_clean_o),
    .cache_wrb_req_o     (cache_wrb_req_o),
    .dcache_flush_o      (dcache_flush_o),
    .evict_index_o       (evict_index_o),
    .dcache2mem_req_o    (dcache2mem_req_o),
    .dcache2mem_wr_o     (dcache2mem_wr_o),
    .mem2dcache_ack_i    (mem2dcache_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic chk_idx; logic [IDX-1:0] idx; } xfer_t;
  typedef struct { logic wr; int lat; } ack_t;
  typedef struct { logic wr; logic present; logic dirty; int lat; } vec_t;

  xfer_t exp_mem[$];
  ack_t  exp_ack[$];
  vec_t  vecs[6];

  int tests = 0;
  int fails = 0;

  int unsigned cyc = 0;
  int unsigned issue_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath / memory model state
  logic       acc_present = 1'b0;
  logic       acc_dirty = 1'b0;
  logic [3:0] dirty_map = 4'b0;
  int         mem_lat = 3;
  logic       stray = 1'b0;
  logic       p_hit = 1'b0, p_evict = 1'b0, p_ack = 1'b0;
  int         mcnt = 0;
  logic       mreq_open = 1'b0;
  int         acc_acks = 0, flush_acks = 0, cache_wr_cnt = 0, line_wr_cnt = 0, clean_cnt = 0;
  int unsigned acc_ack_cyc = 0, flush_ack_cyc = 0;
  xfer_t      xm;
  ack_t       am;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] all_outs();
    return {cache_req_o, cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o,
            dcache_flush_o, evict_index_o, dcache2mem_req_o, dcache2mem_wr_o, ack_o,
            dcache_flush_ack_o};
  endfunction

  // Per-cycle responder: drive RAM/memory inputs, then observe the settled cycle.
  always @(negedge clk) begin
    cache_hit_i       = p_hit;
    cache_evict_req_i = p_evict;
    mem2dcache_ack_i  = p_ack | stray;
    #1;
    p_hit = 1'b0; p_evict = 1'b0; p_ack = 1'b0;
    if (rst) begin
      mcnt = 0;
      mreq_open = 1'b0;
    end else begin
      check("excl_pulses", 32'($countones({cache_wr_o, cache_line_wr_o, cache_line_clean_o}) <= 1), 32'd1);
      if (mreq_open) check("mem_req_held", 32'(dcache2mem_req_o), 32'd1);
      mreq_open = dcache2mem_req_o && !mem2dcache_ack_i;
      if (dcache2mem_req_o) begin
        if (mem2dcache_ack_i) begin
          mcnt = 0;
          if (exp_mem.size() == 0) begin
            check("mem_xfer_expected", 32'(exp_mem.size()), 32'd1);
          end else begin
            xm = exp_mem.pop_front();
            check("mem_wr", 32'(dcache2mem_wr_o), 32'(xm.wr));
            check("wrb_sel", 32'(cache_wrb_req_o), 32'(xm.wr));
            if (xm.chk_idx) check("wrb_idx", 32'(evict_index_o), 32'(xm.idx));
          end
        end else begin
          mcnt++;
          if (mcnt >= mem_lat) begin
            p_ack = 1'b1;
            mcnt = 0;
          end
        end
      end
      if (cache_req_o) begin
        if (dcache_flush_o) begin
          p_evict = dirty_map[evict_index_o];
        end else begin
          p_hit   = acc_present;
          p_evict = acc_dirty;
        end
      end
      if (cache_line_wr_o) begin
        line_wr_cnt++;
        acc_present = 1'b1;
        acc_dirty   = 1'b0;
      end
      if (cache_wr_o) cache_wr_cnt++;
      if (cache_line_clean_o) begin
        clean_cnt++;
        dirty_map[evict_index_o] = 1'b0;
      end
      if (ack_o) begin
        acc_acks++;
        acc_ack_cyc = cyc;
        if (exp_ack.size() == 0) begin
          check("ack_expected", 32'(exp_ack.size()), 32'd1);
        end else begin
          am = exp_ack.pop_front();
          check("store_word_wr", 32'(cache_wr_o), 32'(am.wr));
          if (am.lat > 0) check("ack_latency", cyc - issue_cyc + 1, 32'(am.lat));
        end
      end
      if (dcache_flush_ack_o) begin
        flush_acks++;
        flush_ack_cyc = cyc;
      end
    end
  end

  task automatic run_access(input logic wr, input logic present, input logic dirty,
                            input int lat, input int drop_after);
    int nx, exp_lat, a0, cw0, lw0;
    mem_lat = lat;
    acc_present = present;
    acc_dirty = dirty;
    nx = 0;
    if (!present) begin
      if (dirty) begin
        exp_mem.push_back('{1'b1, 1'b0, '0});
        nx++;
      end
      exp_mem.push_back('{1'b0, 1'b0, '0});
      nx++;
    end
    exp_lat = 2 + nx * (lat + 1) + (present ? 0 : 2);
    exp_ack.push_back('{wr, exp_lat});
    a0 = acc_acks; cw0 = cache_wr_cnt; lw0 = line_wr_cnt;
    @(negedge clk);
    issue_cyc = cyc;
    req = 1'b1;
    wr_i = wr;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (drop_after > 0 && i == drop_after) req = 1'b0;
      if (acc_acks != a0) break;
    end
    req = 1'b0;
    wr_i = 1'b0;
    check("ack_count", 32'(acc_acks - a0), 32'd1);
    check("word_wr_count", 32'(cache_wr_cnt - cw0), 32'(wr));
    check("line_wr_count", 32'(line_wr_cnt - lw0), present ? 32'd0 : 32'd1);
    check("mem_xfers_left", 32'(exp_mem.size()), 32'd0);
    exp_mem.delete();
    exp_ack.delete();
  endtask

  task automatic run_flush(input logic with_req);
    int f0, c0, a0;
    dirty_map = 4'b1010;
    mem_lat = 2;
    exp_mem.push_back('{1'b1, 1'b1, 2'd1});
    exp_mem.push_back('{1'b1, 1'b1, 2'd3});
    if (with_req) begin
      acc_present = 1'b1;
      acc_dirty = 1'b0;
      exp_ack.push_back('{1'b0, 0});
    end
    f0 = flush_acks; c0 = clean_cnt; a0 = acc_acks;
    @(negedge clk);
    dcache_flush_i = 1'b1;
    if (with_req) begin
      req = 1'b1;
      wr_i = 1'b0;
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (flush_acks != f0) dcache_flush_i = 1'b0;
      if (acc_acks != a0) req = 1'b0;
      if (flush_acks != f0 && (!with_req || acc_acks != a0)) break;
    end
    dcache_flush_i = 1'b0;
    req = 1'b0;
    @(negedge clk);
    #2;
    check("flush_ack_count", 32'(flush_acks - f0), 32'd1);
    check("clean_count", 32'(clean_cnt - c0), 32'd2);
    check("flush_xfers_left", 32'(exp_mem.size()), 32'd0);
    check("dirty_after_flush", 32'(dirty_map), 32'd0);
    check("evict_index_hold", 32'(evict_index_o), 32'd3);
    if (with_req) begin
      check("access_after_flush", 32'(acc_acks - a0), 32'd1);
      check("flush_before_access", 32'(flush_ack_cyc < acc_ack_cyc), 32'd1);
    end
    exp_mem.delete();
    exp_ack.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 3};  // load hit
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3};  // store hit
    vecs[2] = '{1'b0, 1'b0, 1'b0, 3};  // load miss, clean victim
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2};  // load miss, dirty victim
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5};  // store miss, dirty victim
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1};  // store miss, clean victim

    // Outputs stay low in reset even with requests pending.
    req = 1'b1;
    dcache_flush_i = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("reset_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    dcache_flush_i = 1'b0;
    #2;
    check("post_reset_outputs", 32'(all_outs()), 32'd0);

    for (int v = 0; v < 6; v++)
      run_access(vecs[v].wr, vecs[v].present, vecs[v].dirty, vecs[v].lat, 0);

    // Request withdrawn mid-miss still completes.
    run_access(1'b0, 1'b0, 1'b0, 4, 3);

    run_flush(1'b0);
    run_flush(1'b1);

    // Stray memory acks in IDLE are ignored.
    @(negedge clk);
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("stray_no_mem_req", 32'(dcache2mem_req_o), 32'd0);
      check("stray_no_ack", 32'(ack_o), 32'd0);
    end
    stray = 1'b0;
    run_access(1'b0, 1'b1, 1'b0, 3, 0);

    // Reset in the middle of a writeback.
    mem_lat = 20;
    acc_present = 1'b0;
    acc_dirty = 1'b1;
    @(negedge clk);
    req = 1'b1;
    wr_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (dcache2mem_req_o && dcache2mem_wr_o) break;
    end
    check("reached_wrback", 32'(dcache2mem_wr_o), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    wr_i = 1'b0;
    #2;
    check("rst_mid_wrback_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_mem.delete();
    exp_ack.delete();
    #2;
    check("idle_after_rst_outputs", 32'(all_outs()), 32'd0);
    run_access(1'b0, 1'b1, 1'b0, 3, 0);
    run_access(1'b1, 1'b0, 1'b1, 2, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_dcache_controller.md
WB_DCACHE_CONTROLLER -- requirements
Module: wb_dcache_controller

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 Parameter DCACHE_IDX_BITS, default from cache_defs package, set index width.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 lsummu2dcache_req_i  in  1  LSU/MMU access request; held until ack.
REQ-006 lsummu2dcache_wr_i  in  1  1 = store, 0 = load; valid with req.
REQ-007 dcache2lsummu_ack_o  out  1  one-cycle access completion pulse.
REQ-008 dcache_flush_i  in  1  flush request; held until flush ack.
REQ-009 dcache_flush_ack_o  out  1  one-cycle flush completion pulse.
REQ-010 cache_hit_i, cache_evict_req_i  in  1 each  datapath tag-compare hit; selected line dirty.
REQ-011 cache_req_o  out  1  data/tag RAM enable.
REQ-012 cache_wr_o, cache_line_wr_o, cache_line_clean_o, cache_wrb_req_o  out  1 each  datapath word write, line refill, line clean, writeback address select.
REQ-013 dcache_flush_o  out  1  datapath indexes by evict_index_o.
REQ-014 evict_index_o  out  DCACHE_IDX_BITS  flush line index.
REQ-015 dcache2mem_req_o, dcache2mem_wr_o  out  1 each  memory line request; 1 = writeback, 0 = refill.
REQ-016 mem2dcache_ack_i  in  1  memory line transfer complete.

Function
REQ-017 States: IDLE, CHECK, WRBACK, ALLOC, REFILL_RD, FLUSH_RD, FLUSH_CHECK, FLUSH_WRB, FLUSH_CLEAN, FLUSH_NEXT, FLUSH_DONE.
REQ-018 IDLE: dcache_flush_i -> FLUSH_RD, evict counter cleared; else req -> CHECK with cache_req_o = 1; flush has priority when both asserted.
REQ-019 CHECK (RAM output valid, 1-cycle RAM latency): hit & load -> ack, IDLE; hit & store -> cache_wr_o = 1 and ack in that same cycle, IDLE.
REQ-020 CHECK miss: cache_evict_req_i -> WRBACK; else -> ALLOC.
REQ-021 WRBACK: cache_wrb_req_o = 1, mem req = 1, mem wr = 1 until mem2dcache_ack_i; then -> ALLOC.
REQ-022 ALLOC: mem req = 1, mem wr = 0; on ack, cache_line_wr_o = 1 for that cycle only; then -> REFILL_RD.
REQ-023 REFILL_RD: cache_req_o = 1, -> CHECK; the replayed access must hit; a store's word write follows the refill.
REQ-024 Hit latency: load or store ack at 2nd cycle after req sampled in IDLE; miss adds memory cycles plus 2.
REQ-025 FLUSH_RD: dcache_flush_o = 1, cache_req_o = 1, -> FLUSH_CHECK.
REQ-026 FLUSH_CHECK: dcache_flush_o held; dirty -> FLUSH_WRB; else -> FLUSH_NEXT.
REQ-027 FLUSH_WRB: cache_wrb_req_o, mem req, mem wr = 1 until ack; -> FLUSH_CLEAN.
REQ-028 FLUSH_CLEAN: cache_line_clean_o = 1 for one cycle; -> FLUSH_NEXT.
REQ-029 FLUSH_NEXT: counter == 2^DCACHE_IDX_BITS-1 -> FLUSH_DONE; else counter+1 -> FLUSH_RD. The counter wraps to 0 only via clear.
REQ-030 FLUSH_DONE: flush ack = 1 for one cycle; -> IDLE.
REQ-031 At most one of cache_wr_o, cache_line_wr_o, cache_line_clean_o is high in any cycle.
REQ-032 dcache2mem_req_o never drops before mem2dcache_ack_i; an ack arriving outside WRBACK, ALLOC or FLUSH_WRB is ignored.
REQ-033 LSU req deassertion mid-miss does not abort the miss: the line completes and the ack is still pulsed.

Reset
REQ-034 On rst: state IDLE, evict counter 0, all outputs 0, including evict_index_o = 0.
REQ-035 Reset mid-transaction returns the FSM to IDLE next cycle with no further RAM or memory pulses.

Structure
REQ-036 The state enum type_wb_dcache_states_e and DCACHE_IDX_BITS reside in the shared cache_defs package.
REQ-037 The block is a single module with no sub-module; the FSM and evict counter are registered and outputs are decoded combinationally from state plus inputs.

Verification
REQ-038 Load hit: req=1, wr=0, hit=1 in CHECK -> ack at cycle 2, no mem req.
REQ-039 Store miss, dirty: hit=0, evict=1, mem ack after 5 cycles each -> writeback with wr=1, then refill with wr=0, line_wr pulse, replay hit, cache_wr_o and ack together.
REQ-040 Flush, IDX_BITS=2, lines 1 and 3 dirty -> exactly 2 writebacks (evict_index 1, 3), 2 clean pulses, then flush ack once.
REQ-041 Simultaneous flush and req in IDLE -> flush completes first, then access served.
REQ-042 rst asserted during WRBACK -> next cycle all outputs 0, state IDLE; a later req is served normally.
